// File: rtl/arb_pkg.sv
// Arbiter types: FSM state, default requester count and grant index type.
package arb_pkg;
    localparam int ARB_CPUS = 2;
    localparam int REQ_N    = 2 * ARB_CPUS;
    localparam int GRANT_W  = $clog2(REQ_N);

    typedef logic [GRANT_W-1:0] grant_t;
    typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: the 32-bit machine word and the RAM handshake state.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);
    int w_pos;

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_pos = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = (int'(ptr) + k) % N;
            if (req[w_pos]) begin
                valid = 1'b1;
                idx   = w_pos[W-1:0];
            end
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among CPUS cores (I and D port each).
// Define ARB_PERF_EN to add the busy_cycles performance counter output.
module ram_arbiter
    import arb_pkg::*;
#(
    parameter int CPUS = ARB_CPUS
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [CPUS-1:0]           iREN,
    input  logic [32*CPUS-1:0]        iaddr,
    input  logic [CPUS-1:0]           dREN,
    input  logic [CPUS-1:0]           dWEN,
    input  logic [32*CPUS-1:0]        daddr,
    input  logic [32*CPUS-1:0]        dstore,
    output logic [CPUS-1:0]           iwait,
    output logic [CPUS-1:0]           dwait,
    output logic [32*CPUS-1:0]        iload,
    output logic [32*CPUS-1:0]        dload,
    output logic                      ramREN,
    output logic                      ramWEN,
    output logic [31:0]               ramaddr,
    output logic [31:0]               ramstore,
    input  cpu_types_pkg::ramstate_t  ramstate,
    input  logic [31:0]               ramload
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]               busy_cycles
`endif
);
    localparam int N = 2 * CPUS;
    localparam int W = (N > 1) ? $clog2(N) : 1;

    arb_state_t     r_state;
    logic [W-1:0]   r_grant;
    logic [W-1:0]   r_rr_ptr;

    logic [N-1:0]   w_req;
    logic           w_pick_valid;
    logic [W-1:0]   w_pick_idx;
    logic           w_greq;
    logic           w_done;
    logic           w_release;
    logic [W-1:0]   w_next_ptr;
    int             w_gcpu;

    genvar gi;
    generate
        for (gi = 0; gi < CPUS; gi++) begin : g_core
            assign w_req[2*gi]         = iREN[gi];
            assign w_req[2*gi+1]       = dREN[gi] | dWEN[gi];
            assign iwait[gi]           = ~(w_done && (r_grant == W'(2*gi)));
            assign dwait[gi]           = ~(w_done && (r_grant == W'(2*gi+1)));
            assign iload[32*gi +: 32]  = ramload;
            assign dload[32*gi +: 32]  = ramload;
        end
    endgenerate

    rr_pick #(.N(N), .W(W)) u_pick (
        .req   (w_req),
        .ptr   (r_rr_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_greq     = w_req[r_grant];
    assign w_done     = (r_state == BUSY) && (ramstate == cpu_types_pkg::ACCESS);
    // Leave BUSY on completion, on error (requester re-arbitrates), or when the request vanishes.
    assign w_release  = !w_greq || (ramstate == cpu_types_pkg::ACCESS)
                        || (ramstate == cpu_types_pkg::ERROR);
    assign w_next_ptr = (r_grant == W'(N - 1)) ? '0 : r_grant + 1'b1;

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        w_gcpu   = int'(r_grant) >> 1;
        if (r_state == BUSY && w_greq) begin
            if (r_grant[0]) begin
                ramWEN   = dWEN[w_gcpu];
                ramREN   = dREN[w_gcpu] & ~dWEN[w_gcpu];
                ramaddr  = daddr[w_gcpu*32 +: 32];
                ramstore = dstore[w_gcpu*32 +: 32];
            end else begin
                ramREN   = 1'b1;
                ramaddr  = iaddr[w_gcpu*32 +: 32];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] r_busy_cycles;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_busy_cycles <= '0;
        end else if (r_state == BUSY && r_busy_cycles != 32'hFFFF_FFFF) begin
            r_busy_cycles <= r_busy_cycles + 32'd1;
        end
    end

    assign busy_cycles = r_busy_cycles;
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, reset/abort sequence, rotation scoreboard.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic [1:0]  iREN, dREN, dWEN;
    logic [63:0] iaddr, daddr, dstore;
    logic [1:0]  iwait, dwait;
    logic [63:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    ramstate_t   ramstate;
    ramstate_t   rs_man;
    logic        ram_auto;
`ifdef ARB_PERF_EN
    logic [31:0] busy_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ram_arbiter #(.CPUS(2)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramstate (ramstate),
        .ramload  (ramload)
`ifdef ARB_PERF_EN
        ,
        .busy_cycles (busy_cycles)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM model: completes any enabled access in the same cycle when in auto mode.
    always_comb ramstate = ram_auto ? ((ramREN | ramWEN) ? ACCESS : FREE) : rs_man;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    typedef struct {
        logic [1:0]  iren, dren, dwen;
        ramstate_t   rs;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic [1:0]  iw, dw;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] ir, input logic [1:0] dr, input logic [1:0] dw_in,
                                input ramstate_t rs, input logic ren, input logic wen,
                                input logic [31:0] addr, input logic [31:0] store,
                                input logic [1:0] iw, input logic [1:0] dw);
        vec_t v;
        v.iren = ir;  v.dren = dr;  v.dwen = dw_in; v.rs = rs;
        v.ren = ren;  v.wen = wen;  v.addr = addr;  v.store = store;
        v.iw = iw;    v.dw = dw;
        return v;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  iw, dw;
        int          cyc;
    } exp_t;

    vec_t tbl [19];
    exp_t sb [$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   c;
        nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
        iaddr  = {32'h0000_0140, 32'h0000_0040};
        daddr  = {32'h0000_0080, 32'h0000_0240};
        dstore = {32'hDEAD_BEEF, 32'h1111_2222};
        ramload = 32'h0; rs_man = FREE; ram_auto = 1'b0;

        //             iren   dren   dwen   rs      ren  wen  addr       store         iw     dw
        tbl[0]  = mk(2'b01, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,         2'b11, 2'b11);
        tbl[1]  = mk(2'b01, 2'b00, 2'b00, BUSY,   1, 0, 32'h40,  32'h0,         2'b11, 2'b11);
        tbl[2]  = mk(2'b01, 2'b00, 2'b00, ACCESS, 1, 0, 32'h40,  32'h0,         2'b10, 2'b11);
        tbl[3]  = mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,         2'b11, 2'b11);
        tbl[4]  = mk(2'b00, 2'b10, 2'b10, FREE,   0, 0, 32'h0,   32'h0,         2'b11, 2'b11);
        tbl[5]  = mk(2'b00, 2'b10, 2'b10, BUSY,   0, 1, 32'h80,  32'hDEAD_BEEF, 2'b11, 2'b11);
        tbl[6]  = mk(2'b00, 2'b10, 2'b10, ACCESS, 0, 1, 32'h80,  32'hDEAD_BEEF, 2'b11, 2'b01);
        tbl[7]  = mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,         2'b11, 2'b11);
        tbl[8]  = mk(2'b00, 2'b01, 2'b00, FREE,   0, 0, 32'h0,   32'h0,         2'b11, 2'b11);
        tbl[9]  = mk(2'b10, 2'b01, 2'b00, ERROR,  1, 0, 32'h240, 32'h1111_2222, 2'b11, 2'b11);
        tbl[10] = mk(2'b10, 2'b01, 2'b00, FREE,   0, 0, 32'h0,   32'h0,         2'b11, 2'b11);
        tbl[11] = mk(2'b10, 2'b01, 2'b00, ACCESS, 1, 0, 32'h140, 32'h0,         2'b01, 2'b11);
        tbl[12] = mk(2'b00, 2'b01, 2'b00, FREE,   0, 0, 32'h0,   32'h0,         2'b11, 2'b11);
        tbl[13] = mk(2'b00, 2'b01, 2'b00, ACCESS, 1, 0, 32'h240, 32'h1111_2222, 2'b11, 2'b10);
        tbl[14] = mk(2'b01, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,         2'b11, 2'b11);
        tbl[15] = mk(2'b00, 2'b00, 2'b00, BUSY,   0, 0, 32'h0,   32'h0,         2'b11, 2'b11);
        tbl[16] = mk(2'b01, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,         2'b11, 2'b11);
        tbl[17] = mk(2'b01, 2'b00, 2'b00, ACCESS, 1, 0, 32'h40,  32'h0,         2'b10, 2'b11);
        tbl[18] = mk(2'b00, 2'b00, 2'b00, FREE,   0, 0, 32'h0,   32'h0,         2'b11, 2'b11);

        // Reset values while nRST is held low.
        #1;
        chk("reset_outputs", 128'({ramREN, ramWEN, ramaddr, ramstore, iwait, dwait}),
            128'({1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11}));
`ifdef ARB_PERF_EN
        chk("reset_busy_cycles", 128'(busy_cycles), 128'(32'h0));
`endif
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        // Vector table: inputs applied at the falling edge, outputs checked just after.
        for (int r = 0; r < 19; r++) begin
            @(negedge CLK);
            iREN = tbl[r].iren; dREN = tbl[r].dren; dWEN = tbl[r].dwen;
            rs_man = tbl[r].rs;
            ramload = 32'hC0DE_0000 + 32'(r);
            #1;
            chk($sformatf("row%0d_bus", r),
                128'({ramREN, ramWEN, ramaddr, ramstore, iwait, dwait}),
                128'({tbl[r].ren, tbl[r].wen, tbl[r].addr, tbl[r].store, tbl[r].iw, tbl[r].dw}));
            chk($sformatf("row%0d_load", r), {iload, dload},
                {ramload, ramload, ramload, ramload});
        end

        // Abort an in-flight D1 access with an asynchronous reset.
        @(negedge CLK);
        dREN = 2'b10; rs_man = FREE;
        @(negedge CLK);
        #1;
        chk("d1_granted_before_abort", 128'({ramREN, ramWEN, ramaddr}),
            128'({1'b1, 1'b0, 32'h80}));
        nRST = 1'b0;
        #1;
        chk("abort_outputs", 128'({ramREN, ramWEN, ramaddr, ramstore, iwait, dwait}),
            128'({1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11}));

        // All four held after release: rotation must restart at I0, one completion per 2 cycles.
        @(negedge CLK);
        iREN = 2'b11; dREN = 2'b11; dWEN = 2'b00; ram_auto = 1'b1;
        nRST = 1'b1;
        e.addr = 32'h40;  e.iw = 2'b10; e.dw = 2'b11; e.cyc = 1; sb.push_back(e);
        e.addr = 32'h240; e.iw = 2'b11; e.dw = 2'b10; e.cyc = 3; sb.push_back(e);
        e.addr = 32'h140; e.iw = 2'b01; e.dw = 2'b11; e.cyc = 5; sb.push_back(e);
        e.addr = 32'h80;  e.iw = 2'b11; e.dw = 2'b01; e.cyc = 7; sb.push_back(e);
        e.addr = 32'h40;  e.iw = 2'b10; e.dw = 2'b11; e.cyc = 9; sb.push_back(e);
        c = 0;
        while (sb.size() > 0 && c < 20) begin
            @(negedge CLK);
            #1;
            c++;
            if (iwait != 2'b11 || dwait != 2'b11) begin
                e = sb.pop_front();
                chk($sformatf("rot_access_at_cycle%0d", c),
                    128'({ramaddr, iwait, dwait, 32'(c)}),
                    128'({e.addr, e.iw, e.dw, 32'(e.cyc)}));
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL rot_timeout: %0d accesses outstanding after %0d cycles, required 0", sb.size(), c);
        end

`ifdef ARB_PERF_EN
        // Three I0 accesses with two BUSY cycles each.
        @(negedge CLK);
        nRST = 1'b0; ram_auto = 1'b0; iREN = 2'b00; dREN = 2'b00; rs_man = FREE;
        #1;
        chk("perf_cleared", 128'(busy_cycles), 128'(32'h0));
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); iREN = 2'b01; rs_man = FREE;
            @(negedge CLK); rs_man = BUSY;
            @(negedge CLK); rs_man = ACCESS;
        end
        @(negedge CLK);
        iREN = 2'b00; rs_man = FREE;
        #1;
        chk("perf_busy_cycles", 128'(busy_cycles), 128'(32'd6));
        nRST = 1'b0;
        #1;
        chk("perf_reset_clears", 128'(busy_cycles), 128'(32'h0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
